// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with 1/2/4-lane SIMD split, tag passthrough and flush.
// Define KSA_PIPE_FLAGS_EN to add per-lane carry-out, overflow and zero flag outputs.
module ksa_pipe #(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [1:0]       in_lane_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef KSA_PIPE_FLAGS_EN
    ,
    output logic [3:0]       out_cout,
    output logic [3:0]       out_ovf,
    output logic [3:0]       out_zero
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int STAGES = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
    localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;

    // Prefix levels owned by one stage. A level k combines bit i with bit
    // i-2^(k-1) only when both sit in the same lane, i.e. the offset of i
    // inside its lane is at least 2^(k-1).
    function automatic logic [WIDTH-1:0] prefix_g(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input logic [1:0]       mode,
        input int               stage
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] gs;
        logic [WIDTH-1:0] ps;
        int               lmask;
        g     = g_in;
        p     = p_in;
        lmask = (1 << (LEVELS - int'(mode))) - 1;
        for (int k = 1; k <= LEVELS; k++) begin
            if (k > (stage - 1) * LEVELS_PER_STAGE && k <= stage * LEVELS_PER_STAGE) begin
                gs = g << (1 << (k - 1));
                ps = p << (1 << (k - 1));
                for (int i = 0; i < WIDTH; i++) begin
                    if ((i & lmask) >= (1 << (k - 1))) begin
                        g[i] = g[i] | (p[i] & gs[i]);
                        p[i] = p[i] & ps[i];
                    end
                end
            end
        end
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] prefix_p(
        input logic [WIDTH-1:0] p_in,
        input logic [1:0]       mode,
        input int               stage
    );
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] ps;
        int               lmask;
        p     = p_in;
        lmask = (1 << (LEVELS - int'(mode))) - 1;
        for (int k = 1; k <= LEVELS; k++) begin
            if (k > (stage - 1) * LEVELS_PER_STAGE && k <= stage * LEVELS_PER_STAGE) begin
                ps = p << (1 << (k - 1));
                for (int i = 0; i < WIDTH; i++) begin
                    if ((i & lmask) >= (1 << (k - 1))) begin
                        p[i] = p[i] & ps[i];
                    end
                end
            end
        end
        return p;
    endfunction

    // Pipeline registers
    logic [STAGES:1]  r_v;
    logic [WIDTH-1:0] r_g    [1:MID];
    logic [WIDTH-1:0] r_p    [1:MID];
    logic [WIDTH-1:0] r_p0   [1:MID];
    logic             r_sub  [1:MID];
    logic [1:0]       r_mode [1:MID];
    logic [TAG_W-1:0] r_tag  [1:STAGES];
    logic [WIDTH-1:0] r_result;

    // Stage inputs / outputs
    logic [WIDTH-1:0] w_in_g    [1:STAGES];
    logic [WIDTH-1:0] w_in_p    [1:STAGES];
    logic [WIDTH-1:0] w_in_p0   [1:STAGES];
    logic             w_in_sub  [1:STAGES];
    logic [1:0]       w_in_mode [1:STAGES];
    logic [TAG_W-1:0] w_in_tag  [1:STAGES];
    logic [WIDTH-1:0] w_out_g   [1:MID];
    logic [WIDTH-1:0] w_out_p   [1:MID];

    logic [WIDTH-1:0] w_l0_g;
    logic [WIDTH-1:0] w_l0_p;
    logic [WIDTH-1:0] w_b_eff;
    logic [1:0]       w_l0_mode;
    logic [WIDTH-1:0] w_fin_g;
    logic [WIDTH-1:0] w_fin_carry;
    logic [WIDTH-1:0] w_sum;
    logic [STAGES:1]  w_adv;
    logic [STAGES:1]  w_vin;
    logic             w_accept;

    // Level 0: generate/propagate, with the lane carry-in folded into each lane LSB.
    always_comb begin
        int lmask;
        w_l0_mode = (in_lane_mode == 2'd3) ? 2'd0 : in_lane_mode;
        lmask     = (1 << (LEVELS - int'(w_l0_mode))) - 1;
        w_b_eff   = in_b ^ {WIDTH{in_sub}};
        w_l0_p    = in_a ^ w_b_eff;
        w_l0_g    = in_a & w_b_eff;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i & lmask) == 0) begin
                w_l0_g[i] = w_l0_g[i] | (w_l0_p[i] & in_sub);
            end
        end
    end

    assign w_in_g[1]    = w_l0_g;
    assign w_in_p[1]    = w_l0_p;
    assign w_in_p0[1]   = w_l0_p;
    assign w_in_sub[1]  = in_sub;
    assign w_in_mode[1] = w_l0_mode;
    assign w_in_tag[1]  = in_tag;

    generate
        for (genvar gi = 2; gi <= STAGES; gi++) begin : g_stage_in
            assign w_in_g[gi]    = r_g[gi-1];
            assign w_in_p[gi]    = r_p[gi-1];
            assign w_in_p0[gi]   = r_p0[gi-1];
            assign w_in_sub[gi]  = r_sub[gi-1];
            assign w_in_mode[gi] = r_mode[gi-1];
            assign w_in_tag[gi]  = r_tag[gi-1];
        end
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage_pfx
            assign w_out_g[gi] = prefix_g(w_in_g[gi], w_in_p[gi], w_in_mode[gi], gi);
            assign w_out_p[gi] = prefix_p(w_in_p[gi], w_in_mode[gi], gi);
        end
    endgenerate

    // Last stage finishes the prefix tree and forms the sum before its register.
    assign w_fin_g     = prefix_g(w_in_g[STAGES], w_in_p[STAGES], w_in_mode[STAGES], STAGES);
    assign w_fin_carry = {w_fin_g[WIDTH-2:0], 1'b0};

    always_comb begin
        int lmask;
        lmask = (1 << (LEVELS - int'(w_in_mode[STAGES]))) - 1;
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i & lmask) == 0) begin
                w_sum[i] = w_in_p0[STAGES][i] ^ w_in_sub[STAGES];
            end else begin
                w_sum[i] = w_in_p0[STAGES][i] ^ w_fin_carry[i];
            end
        end
    end

    // Elastic handshake: a stage may load when the stage downstream is empty or moving.
    always_comb begin
        w_adv         = '0;
        w_adv[STAGES] = out_ready | ~r_v[STAGES];
        for (int s = STAGES - 1; s >= 1; s--) begin
            w_adv[s] = ~r_v[s+1] | w_adv[s+1];
        end
    end

    assign in_ready = (~r_v[1] | w_adv[1]) & ~flush;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_vin    = '0;
        w_vin[1] = w_accept;
        for (int s = 2; s <= STAGES; s++) begin
            w_vin[s] = r_v[s-1];
        end
    end

`ifdef KSA_PIPE_FLAGS_EN
    logic [3:0] r_cout;
    logic [3:0] r_ovf;
    logic [3:0] r_zero;
    logic [3:0] w_cout;
    logic [3:0] w_ovf;
    logic [3:0] w_zero;

    always_comb begin
        int   lw;
        int   lmask;
        logic nz;
        lw     = LEVELS - int'(w_in_mode[STAGES]);
        lmask  = (1 << lw) - 1;
        w_cout = '0;
        w_ovf  = '0;
        w_zero = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < (1 << int'(w_in_mode[STAGES]))) begin
                nz = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if ((i >> lw) == j) begin
                        nz = nz | w_sum[i];
                        if ((i & lmask) == lmask) begin
                            w_cout[j] = w_fin_g[i];
                            w_ovf[j]  = w_fin_g[i] ^ w_fin_carry[i];
                        end
                    end
                end
                w_zero[j] = ~nz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cout <= '0;
            r_ovf  <= '0;
            r_zero <= '0;
        end else if (w_adv[STAGES]) begin
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;
    assign out_zero = r_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v      <= '0;
            r_result <= '0;
            for (int s = 1; s <= MID; s++) begin
                r_g[s]    <= '0;
                r_p[s]    <= '0;
                r_p0[s]   <= '0;
                r_sub[s]  <= 1'b0;
                r_mode[s] <= 2'd0;
            end
            for (int s = 1; s <= STAGES; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (w_adv[s]) begin
                    r_v[s]   <= w_vin[s];
                    r_tag[s] <= w_in_tag[s];
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (w_adv[s]) begin
                    r_g[s]    <= w_out_g[s];
                    r_p[s]    <= w_out_p[s];
                    r_p0[s]   <= w_in_p0[s];
                    r_sub[s]  <= w_in_sub[s];
                    r_mode[s] <= w_in_mode[s];
                end
            end
            if (w_adv[STAGES]) begin
                r_result <= w_sum;
            end
            // Flush only kills validity; stale data behind a cleared valid is harmless.
            if (flush) begin
                r_v <= '0;
            end
        end
    end

    assign out_valid  = r_v[STAGES];
    assign out_result = r_result;
    assign out_tag    = r_tag[STAGES];

endmodule

// File: tb/tb_ksa_pipe.sv
// Directed self-checking bench for ksa_pipe (WIDTH=32, LEVELS_PER_STAGE=2 -> 3 stages).
// Flag outputs are checked too when KSA_PIPE_FLAGS_EN is defined.
module tb_ksa_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [1:0]  in_lane_mode;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
`ifdef KSA_PIPE_FLAGS_EN
    logic [3:0]  out_cout;
    logic [3:0]  out_ovf;
    logic [3:0]  out_zero;
    logic [3:0]  cap_cout;
    logic [3:0]  cap_ovf;
    logic [3:0]  cap_zero;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cap_result;
    logic [5:0]  cap_tag;
    int          cap_lat;

    always #5 clk = ~clk;

    ksa_pipe #(
        .WIDTH           (32),
        .LEVELS_PER_STAGE(2),
        .TAG_W           (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sub      (in_sub),
        .in_lane_mode(in_lane_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag)
`ifdef KSA_PIPE_FLAGS_EN
        ,
        .out_cout    (out_cout),
        .out_ovf     (out_ovf),
        .out_zero    (out_zero)
`endif
    );

    // Drive one op into an empty pipe and capture the first result; cap_lat = -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [1:0] mode, input logic [5:0] tag);
        bit found;
        in_valid     = 1'b1;
        in_a         = a;
        in_b         = b;
        in_sub       = sub;
        in_lane_mode = mode;
        in_tag       = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cap_lat  = 1;
        found    = 1'b0;
        while (cap_lat <= 10 && !found) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                found      = 1'b1;
                cap_result = out_result;
                cap_tag    = out_tag;
`ifdef KSA_PIPE_FLAGS_EN
                cap_cout   = out_cout;
                cap_ovf    = out_ovf;
                cap_zero   = out_zero;
`endif
            end else begin
                @(posedge clk);
                #1;
                cap_lat++;
            end
        end
        if (found) begin
            @(posedge clk);
            #1;
        end else begin
            cap_lat = -1;
        end
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_sub       = 1'b0;
        in_lane_mode = 2'd0;
        in_tag       = '0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
        n_tests++; if (out_tag !== 6'd0) begin n_fail++; $display("FAIL reset_out_tag: got %0d expected 0", out_tag); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        $display("[TB] reset: out_valid=%b out_result=%h out_tag=%0d in_ready=%b", out_valid, out_result, out_tag, in_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic test_add;
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 2'd0, 6'd5);
        $display("[TB] add: result=%h tag=%0d latency=%0d", cap_result, cap_tag, cap_lat);
        n_tests++; if (cap_lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", cap_lat); end
        n_tests++; if (cap_result !== 32'h0) begin n_fail++; $display("FAIL add_result: got %h expected 00000000", cap_result); end
        n_tests++; if (cap_tag !== 6'd5) begin n_fail++; $display("FAIL add_tag: got %0d expected 5", cap_tag); end
`ifdef KSA_PIPE_FLAGS_EN
        n_tests++; if (cap_cout !== 4'b0001) begin n_fail++; $display("FAIL add_cout: got %b expected 0001", cap_cout); end
        n_tests++; if (cap_ovf !== 4'b0000) begin n_fail++; $display("FAIL add_ovf: got %b expected 0000", cap_ovf); end
        n_tests++; if (cap_zero !== 4'b0001) begin n_fail++; $display("FAIL add_zero: got %b expected 0001", cap_zero); end
`endif
    endtask

    task automatic test_sub_lanes;
        run_op(32'h0001_8000, 32'h0002_0001, 1'b1, 2'd1, 6'd6);
        $display("[TB] sub_lanes: result=%h tag=%0d latency=%0d", cap_result, cap_tag, cap_lat);
        n_tests++; if (cap_lat !== 3) begin n_fail++; $display("FAIL sub_latency: got %0d expected 3", cap_lat); end
        n_tests++; if (cap_result !== 32'hFFFF_7FFF) begin n_fail++; $display("FAIL sub_result: got %h expected ffff7fff", cap_result); end
        n_tests++; if (cap_tag !== 6'd6) begin n_fail++; $display("FAIL sub_tag: got %0d expected 6", cap_tag); end
`ifdef KSA_PIPE_FLAGS_EN
        n_tests++; if (cap_cout !== 4'b0001) begin n_fail++; $display("FAIL sub_cout: got %b expected 0001", cap_cout); end
        n_tests++; if (cap_ovf !== 4'b0001) begin n_fail++; $display("FAIL sub_ovf: got %b expected 0001", cap_ovf); end
        n_tests++; if (cap_zero !== 4'b0000) begin n_fail++; $display("FAIL sub_zero: got %b expected 0000", cap_zero); end
`endif
    endtask

    task automatic test_quarters;
        run_op(32'h7FFF_0180, 32'h0101_FF80, 1'b0, 2'd2, 6'd7);
        $display("[TB] quarters: result=%h tag=%0d latency=%0d", cap_result, cap_tag, cap_lat);
        n_tests++; if (cap_lat !== 3) begin n_fail++; $display("FAIL quarters_latency: got %0d expected 3", cap_lat); end
        n_tests++; if (cap_result !== 32'h8000_0000) begin n_fail++; $display("FAIL quarters_result: got %h expected 80000000", cap_result); end
        n_tests++; if (cap_tag !== 6'd7) begin n_fail++; $display("FAIL quarters_tag: got %0d expected 7", cap_tag); end
`ifdef KSA_PIPE_FLAGS_EN
        n_tests++; if (cap_cout !== 4'b0111) begin n_fail++; $display("FAIL quarters_cout: got %b expected 0111", cap_cout); end
        n_tests++; if (cap_ovf !== 4'b1001) begin n_fail++; $display("FAIL quarters_ovf: got %b expected 1001", cap_ovf); end
        n_tests++; if (cap_zero !== 4'b0111) begin n_fail++; $display("FAIL quarters_zero: got %b expected 0111", cap_zero); end
`endif
    endtask

    // Lane-boundary and reserved-mode vectors with hand-computed results.
    task automatic test_lane_modes;
        logic [31:0] va   [5] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0005, 32'h1020_3040, 32'h0000_0000};
        logic [31:0] vb   [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0101_0101, 32'h0000_0001};
        logic        vsub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  vmode[5] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2};
        logic [31:0] vexp [5] = '{32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0F1F_2F3F, 32'h0000_00FF};
        for (int v = 0; v < 5; v++) begin
            run_op(va[v], vb[v], vsub[v], vmode[v], 6'(20 + v));
            $display("[TB] lane_mode vec%0d: mode=%0d sub=%b result=%h latency=%0d", v, vmode[v], vsub[v], cap_result, cap_lat);
            n_tests++; if (cap_lat !== 3) begin n_fail++; $display("FAIL lane_mode%0d_latency: got %0d expected 3", v, cap_lat); end
            n_tests++; if (cap_result !== vexp[v]) begin n_fail++; $display("FAIL lane_mode%0d_result: got %h expected %h", v, cap_result, vexp[v]); end
        end
    endtask

    task automatic test_backpressure;
        int   sent;
        int   got;
        int   cyc;
        int   last_cyc;
        logic rdy;
        logic ov;
        logic [5:0]  ot;
        logic [31:0] ores;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        last_cyc  = -1;
        out_ready = 1'b0;
        in_sub       = 1'b0;
        in_lane_mode = 2'd0;
        while (got < 8 && cyc < 40) begin
            in_valid = (sent < 8);
            in_a     = 32'(sent);
            in_b     = 32'h100;
            in_tag   = 6'(sent);
            if (cyc == 6) out_ready = 1'b1;
            @(negedge clk);
            rdy  = in_ready;
            ov   = out_valid;
            ot   = out_tag;
            ores = out_result;
            if (cyc == 5) begin
                $display("[TB] backpressure stalled: accepted=%0d in_ready=%b out_valid=%b out_tag=%0d", sent, rdy, ov, ot);
                n_tests++; if (sent !== 3) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 3", sent); end
                n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", rdy); end
                n_tests++; if (ov !== 1'b1 || ot !== 6'd0) begin n_fail++; $display("FAIL bp_head: got valid=%b tag=%0d expected valid=1 tag=0", ov, ot); end
            end
            if (ov === 1'b1 && out_ready) begin
                $display("[TB] backpressure out: cycle=%0d tag=%0d result=%h", cyc, ot, ores);
                n_tests++; if (ot !== 6'(got)) begin n_fail++; $display("FAIL bp_order: got tag %0d expected %0d", ot, got); end
                n_tests++; if (ores !== 32'h100 + 32'(got)) begin n_fail++; $display("FAIL bp_result: got %h expected %h", ores, 32'h100 + 32'(got)); end
                if (got > 0) begin
                    n_tests++; if (cyc !== last_cyc + 1) begin n_fail++; $display("FAIL bp_gap: got cycle %0d expected %0d", cyc, last_cyc + 1); end
                end
                last_cyc = cyc;
                got++;
            end
            if (in_valid && rdy === 1'b1) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++; if (got !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", got); end
    endtask

    task automatic test_flush;
        int seen;
        out_ready    = 1'b1;
        in_sub       = 1'b0;
        in_lane_mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = 32'(k);
            in_b     = 32'h10;
            in_tag   = 6'(10 + k);
            @(posedge clk);
            #1;
        end
        flush  = 1'b1;
        in_tag = 6'd13;
        @(negedge clk);
        $display("[TB] flush cycle: in_ready=%b out_valid=%b", in_ready, out_valid);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        seen     = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        $display("[TB] flush after: out_valid cycles=%0d", seen);
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL flush_killed: got %0d valid cycles expected 0", seen); end
        run_op(32'd100, 32'd23, 1'b0, 2'd0, 6'd14);
        $display("[TB] flush next op: result=%h tag=%0d latency=%0d", cap_result, cap_tag, cap_lat);
        n_tests++; if (cap_lat !== 3) begin n_fail++; $display("FAIL flush_next_latency: got %0d expected 3", cap_lat); end
        n_tests++; if (cap_result !== 32'd123) begin n_fail++; $display("FAIL flush_next_result: got %h expected %h", cap_result, 32'd123); end
        n_tests++; if (cap_tag !== 6'd14) begin n_fail++; $display("FAIL flush_next_tag: got %0d expected 14", cap_tag); end
    endtask

    task automatic test_reset_midop;
        out_ready    = 1'b0;
        in_sub       = 1'b0;
        in_lane_mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = 32'hA0 + 32'(k);
            in_b     = 32'h1;
            in_tag   = 6'(30 + k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_tag !== 6'd30) begin n_fail++; $display("FAIL midop_full: got valid=%b tag=%0d expected valid=1 tag=30", out_valid, out_tag); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        $display("[TB] reset midop: out_valid=%b out_result=%h out_tag=%0d", out_valid, out_result, out_tag);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL midop_out_result: got %h expected 0", out_result); end
        n_tests++; if (out_tag !== 6'd0) begin n_fail++; $display("FAIL midop_out_tag: got %0d expected 0", out_tag); end
`ifdef KSA_PIPE_FLAGS_EN
        n_tests++; if ({out_cout, out_ovf, out_zero} !== 12'h0) begin n_fail++; $display("FAIL midop_flags: got %h expected 000", {out_cout, out_ovf, out_zero}); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midop_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_after_valid: got %b expected 0", out_valid); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_lanes();
        test_quarters();
        test_lane_modes();
        test_backpressure();
        test_flush();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
